// File: rtl/fifo_unpack_m.sv
// FWFT FIFO read-side unpacker: serialises each RATIO-item word onto a valid/ready stream, LSB item
// first. Optional accepted-item counter is built only when FIFO_UNPACK_CNT_EN is defined.
module fifo_unpack_m #(
    parameter type         ITEM_TYPE = logic [7:0],
    parameter int unsigned RATIO     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [RATIO*$bits(ITEM_TYPE)-1:0]     head,
    input  logic                                  empty,
    output logic                                  pop,
    output ITEM_TYPE                              out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic [31:0]                           item_cnt
);

    localparam int unsigned IW      = $bits(ITEM_TYPE);
    localparam int unsigned WW      = RATIO * IW;
    localparam int unsigned IdxW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            xfer;
    logic            at_last;
    logic            load;

    assign out_valid = (state_q == StShift);
    assign xfer      = out_valid && out_ready;
    assign at_last   = (idx_q == LastIdx);
    assign out_last  = out_valid && at_last;
    assign out_data  = word_q[idx_q*IW +: IW];

    // Reload either from idle or exactly as the last item of the current word leaves.
    assign load = !empty && ((state_q == StIdle) || (xfer && at_last));
    // While held in reset nothing is captured, so a pop would silently drop a word.
    assign pop  = load && rst_n;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StShift;
                    word_d  = head;
                    idx_d   = '0;
                end
            end
            StShift: begin
                if (xfer) begin
                    if (!at_last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (load) begin
                        word_d = head;
                        idx_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

`ifdef FIFO_UNPACK_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign item_cnt = cnt_q;
`else
    assign item_cnt = '0;
`endif

endmodule
